wprcnt_checker: RTL and testbench

Lockstep checker sitting on the consuming side of the wrap-counter interface. It accepts the three 5-bit count streams produced by the Bluespec, Chisel and MyHDL counter implementations, which run on the same clock. It acquires a common starting value and tracks an internal reference wrap counter. It flags, counts and captures any divergence, so co-simulation and hardware runs share one pass/fail monitor.

---
 rtl/wprcnt_pkg.sv | 24 ++
 rtl/wprcnt_ref.sv | 32 +++
 rtl/wprcnt_checker.sv | 144 ++++++++++++++
 tb/tb_wprcnt_checker.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wprcnt_pkg.sv
// Shared types and constants for the wrap-counter lockstep checker.
package wprcnt_pkg;

    typedef enum logic [1:0] {
        ACQUIRE = 2'd0,
        TRACK   = 2'd1,
        FAULT   = 2'd2
    } state_t;

    localparam int CNT_W = 8;
    localparam int IDX_W = 16;
    localparam int NSTR  = 3;

    // Stream indices; err bit order is {m,c,b}
    localparam int B = 0;
    localparam int C = 1;
    localparam int M = 2;

    // Saturating increment for the per-stream mismatch counters
    function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/wprcnt_ref.sv
// Loadable reference wrap counter. A load seeds the counter one step past
// the loaded value, so the output is the value expected on the next edge.
module wprcnt_ref #(
    parameter int WIDTH = 5,
    parameter int WRAP  = 31
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             adv,
    output logic [WIDTH-1:0] value
);

    localparam logic [WIDTH-1:0] WRAP_V = WIDTH'(WRAP);

    // Successor with wrap; values above WRAP simply truncate on overflow
    function automatic logic [WIDTH-1:0] wrap_next(input logic [WIDTH-1:0] v);
        return (v == WRAP_V) ? '0 : v + WIDTH'(1);
    endfunction

    // Load takes priority over advance; clear returns to zero
    always_ff @(posedge clock) begin
        if (clear)
            value <= '0;
        else if (load)
            value <= wrap_next(load_val);
        else if (adv)
            value <= wrap_next(value);
    end

endmodule

// File: rtl/wprcnt_checker.sv
// Lockstep checker for three wrap-counter streams (b, c, m).
// Acquires a common start value, then compares every stream against an
// internal reference and records mismatches until a per-stream limit trips.
// Optional build macro WPRCNT_CHK_MAJORITY_EN: lock on a 2-of-3 majority
// instead of requiring all three streams to agree.
module wprcnt_checker
    import wprcnt_pkg::*;
#(
    parameter int WIDTH     = 5,
    parameter int WRAP      = 31,
    parameter int ERR_LIMIT = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clr,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_c,
    input  logic [WIDTH-1:0] in_m,
    output logic             locked,
    output logic             fault,
    output logic [2:0]       err,
    output logic [CNT_W-1:0] cnt_b,
    output logic [CNT_W-1:0] cnt_c,
    output logic [CNT_W-1:0] cnt_m,
    output logic [WIDTH-1:0] first_exp,
    output logic [IDX_W-1:0] first_idx,
    output logic [IDX_W-1:0] samples
);

    state_t                        state;
    logic                          clear;
    logic                          tracking;
    logic                          agree;
    logic [WIDTH-1:0]              acq_v;
    logic [WIDTH-1:0]              exp_val;
    logic [NSTR-1:0][WIDTH-1:0]    vin;
    logic [NSTR-1:0]               mm;
    logic [NSTR-1:0][CNT_W-1:0]    cnt_q;
    logic [NSTR-1:0][CNT_W-1:0]    cnt_nxt;
    logic                          hit;
    logic                          have_first;

    assign clear    = reset | clr;
    assign tracking = (state == TRACK);
    assign vin      = {in_m, in_c, in_b};

    // Agreement detection used only while acquiring
    always_comb begin
        agree = 1'b0;
        acq_v = in_b;
`ifdef WPRCNT_CHK_MAJORITY_EN
        if (in_b == in_c || in_b == in_m) begin
            agree = 1'b1;
            acq_v = in_b;
        end else if (in_c == in_m) begin
            agree = 1'b1;
            acq_v = in_c;
        end
`else
        agree = (in_b == in_c) && (in_b == in_m);
`endif
    end

    wprcnt_ref #(
        .WIDTH (WIDTH),
        .WRAP  (WRAP)
    ) u_ref (
        .clock    (clock),
        .clear    (clear),
        .load     ((state == ACQUIRE) && agree),
        .load_val (acq_v),
        .adv      (tracking),
        .value    (exp_val)
    );

    // Per-stream compare, next counts and the fault trigger
    always_comb begin
        mm      = '0;
        cnt_nxt = cnt_q;
        hit     = 1'b0;
        for (int i = 0; i < NSTR; i++) begin
            mm[i] = tracking && (vin[i] != exp_val);
            if (mm[i]) begin
                cnt_nxt[i] = cnt_sat_inc(cnt_q[i]);
                if (int'(cnt_nxt[i]) >= ERR_LIMIT)
                    hit = 1'b1;
            end
        end
    end

    // Mode FSM with registered status outputs
    always_ff @(posedge clock) begin
        if (clear) begin
            state  <= ACQUIRE;
            locked <= 1'b0;
            fault  <= 1'b0;
        end else begin
            case (state)
                ACQUIRE: if (agree) begin
                    state  <= TRACK;
                    locked <= 1'b1;
                end
                TRACK: if (hit) begin
                    state  <= FAULT;
                    locked <= 1'b0;
                    fault  <= 1'b1;
                end
                FAULT: ;
                default: begin
                    state  <= ACQUIRE;
                    locked <= 1'b0;
                    fault  <= 1'b0;
                end
            endcase
        end
    end

    // Statistics and first-mismatch capture; frozen outside TRACK
    always_ff @(posedge clock) begin
        if (clear) begin
            err        <= '0;
            cnt_q      <= '0;
            first_exp  <= '0;
            first_idx  <= '1;
            samples    <= '0;
            have_first <= 1'b0;
        end else if (tracking) begin
            err   <= err | mm;
            cnt_q <= cnt_nxt;
            if (|mm && !have_first) begin
                first_exp  <= exp_val;
                first_idx  <= samples;
                have_first <= 1'b1;
            end
            if (samples != {IDX_W{1'b1}})
                samples <= samples + IDX_W'(1);
        end
    end

    assign cnt_b = cnt_q[B];
    assign cnt_c = cnt_q[C];
    assign cnt_m = cnt_q[M];

endmodule

// File: tb/tb_wprcnt_checker.sv
// Self-checking bench for wprcnt_checker: directed scenarios plus a
// randomized run against a behavioural model of the checker rules.
module tb_wprcnt_checker;

    localparam int WIDTH     = 5;
    localparam int WRAP      = 31;
    localparam int ERR_LIMIT = 4;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             clr   = 1'b0;
    logic [WIDTH-1:0] in_b  = '0;
    logic [WIDTH-1:0] in_c  = '0;
    logic [WIDTH-1:0] in_m  = '0;
    logic             locked;
    logic             fault;
    logic [2:0]       err;
    logic [7:0]       cnt_b, cnt_c, cnt_m;
    logic [WIDTH-1:0] first_exp;
    logic [15:0]      first_idx;
    logic [15:0]      samples;

    int checks = 0;
    int errors = 0;

    wprcnt_checker #(.WIDTH(WIDTH), .WRAP(WRAP), .ERR_LIMIT(ERR_LIMIT)) dut (
        .clock(clock), .reset(reset), .clr(clr),
        .in_b(in_b), .in_c(in_c), .in_m(in_m),
        .locked(locked), .fault(fault), .err(err),
        .cnt_b(cnt_b), .cnt_c(cnt_c), .cnt_m(cnt_m),
        .first_exp(first_exp), .first_idx(first_idx), .samples(samples)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    // ---------------- behavioural model ----------------
    // mode: 0 acquiring, 1 tracking, 2 faulted
    int       mode;
    int       mexp;
    int       mcnt [3];
    logic [2:0] merr;
    int       mfirst_exp, mfirst_idx, msamples;
    bit       mhave;

    function automatic void model_clear();
        mode = 0; mexp = 0; merr = 3'b000;
        for (int i = 0; i < 3; i++) mcnt[i] = 0;
        mfirst_exp = 0; mfirst_idx = 16'hFFFF; msamples = 0; mhave = 0;
    endfunction

    function automatic void model_edge(input int b, input int c, input int m, input bit cl);
        int  v [3];
        int  acq;
        bit  ok;
        bit  any;
        v[0] = b; v[1] = c; v[2] = m;
        if (cl) begin
            model_clear();
            return;
        end
        if (mode == 0) begin
            ok = 0; acq = 0;
`ifdef WPRCNT_CHK_MAJORITY_EN
            if (b == c || b == m) begin ok = 1; acq = b; end
            else if (c == m) begin ok = 1; acq = c; end
`else
            if (b == c && c == m) begin ok = 1; acq = b; end
`endif
            if (ok) begin
                mexp = (acq == WRAP) ? 0 : (acq + 1) % (1 << WIDTH);
                mode = 1;
            end
        end else if (mode == 1) begin
            any = 0;
            for (int i = 0; i < 3; i++) begin
                if (v[i] != mexp) begin
                    merr[i] = 1'b1;
                    if (mcnt[i] < 255) mcnt[i]++;
                    any = 1;
                end
            end
            if (any && !mhave) begin
                mfirst_exp = mexp; mfirst_idx = msamples; mhave = 1;
            end
            if (msamples < 65535) msamples++;
            mexp = (mexp == WRAP) ? 0 : mexp + 1;
            for (int i = 0; i < 3; i++)
                if (mcnt[i] >= ERR_LIMIT) mode = 2;
        end
    endfunction

    // Drive one edge worth of inputs and advance the model alongside it
    task automatic tick(input int b, input int c, input int m, input bit cl);
        in_b = WIDTH'(b); in_c = WIDTH'(c); in_m = WIDTH'(m); clr = cl;
        @(posedge clock);
        model_edge(b % 32, c % 32, m % 32, cl);
        #1;
        clr = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        #1;
        reset = 1'b1;
        @(posedge clock);
        model_clear();
        #1;
        reset = 1'b0;
        checks++; if ({locked, fault, err} !== 5'b0) begin errors++;
            $display("FAIL reset_status got %b want 00000", {locked, fault, err}); end
        checks++; if ({cnt_b, cnt_c, cnt_m} !== 24'h0) begin errors++;
            $display("FAIL reset_cnt got %h want 000000", {cnt_b, cnt_c, cnt_m}); end
        checks++; if (first_exp !== 5'd0 || first_idx !== 16'hFFFF) begin errors++;
            $display("FAIL reset_first got exp=%0d idx=%h want 0/ffff", first_exp, first_idx); end
        checks++; if (samples !== 16'd0) begin errors++;
            $display("FAIL reset_samples got %0d want 0", samples); end
    endtask

    task automatic test_ramp();
        tick(7, 7, 7, 0);
        checks++; if (locked !== 1'b1) begin errors++;
            $display("FAIL ramp_lock got %b want 1", locked); end
        for (int k = 1; k <= 100; k++) tick((7 + k) % 32, (7 + k) % 32, (7 + k) % 32, 0);
        checks++; if (err !== 3'b000 || samples !== 16'd100) begin errors++;
            $display("FAIL ramp_stats got err=%b samples=%0d want 000/100", err, samples); end
        checks++; if (first_idx !== 16'hFFFF || locked !== 1'b1) begin errors++;
            $display("FAIL ramp_first got idx=%h locked=%b want ffff/1", first_idx, locked); end
    endtask

    task automatic test_wrap();
        tick(0, 0, 0, 1);
        tick(30, 30, 30, 0);
        tick(31, 31, 31, 0);
        tick(0, 32, 0, 0);
        tick(1, 1, 1, 0);
        checks++; if (err !== 3'b000 || samples !== 16'd3) begin errors++;
            $display("FAIL wrap_clean got err=%b samples=%0d want 000/3", err, samples); end
        // m holds WRAP across the wrap point
        tick(0, 0, 0, 1);
        tick(30, 30, 30, 0);
        tick(31, 31, 31, 0);
        tick(0, 0, 31, 0);
        checks++; if (err !== 3'b100 || first_exp !== 5'd0 || first_idx !== 16'd1) begin errors++;
            $display("FAIL wrap_hold got err=%b exp=%0d idx=%0d want 100/0/1", err, first_exp, first_idx); end
    endtask

    task automatic test_stuck();
        tick(0, 0, 0, 1);
        tick(10, 10, 10, 0);
        for (int k = 0; k < 20 && !fault; k++) begin
            tick(11 + k, 11 + k, 12, 0);
            if (k == 0) begin
                checks++; if (err !== 3'b100 || cnt_m !== 8'd1 || first_exp !== 5'd11 || first_idx !== 16'd0) begin
                    errors++;
                    $display("FAIL stuck_first got err=%b cnt_m=%0d exp=%0d idx=%0d want 100/1/11/0",
                             err, cnt_m, first_exp, first_idx);
                end
            end else if (k == 1) begin
                checks++; if (cnt_m !== 8'd1) begin errors++;
                    $display("FAIL stuck_match got cnt_m=%0d want 1", cnt_m); end
            end
        end
        checks++; if (fault !== 1'b1 || cnt_m !== 8'd4 || samples !== 16'd5) begin errors++;
            $display("FAIL stuck_fault got fault=%b cnt_m=%0d samples=%0d want 1/4/5", fault, cnt_m, samples); end
        for (int k = 0; k < 3; k++) tick(k, 20, 3, 0);
        checks++; if (cnt_m !== 8'd4 || samples !== 16'd5 || locked !== 1'b0 || cnt_b !== 8'd0) begin errors++;
            $display("FAIL stuck_freeze got cnt_m=%0d samples=%0d locked=%b cnt_b=%0d want 4/5/0/0",
                     cnt_m, samples, locked, cnt_b); end
    endtask

    task automatic test_clr_in_fault();
        tick(1, 2, 3, 1);
        checks++; if ({cnt_b, cnt_c, cnt_m} !== 24'h0 || err !== 3'b000 || samples !== 16'd0) begin errors++;
            $display("FAIL clr_stats got cnt=%h err=%b samples=%0d want 0", {cnt_b, cnt_c, cnt_m}, err, samples); end
        checks++; if (locked !== 1'b0 || fault !== 1'b0 || first_idx !== 16'hFFFF) begin errors++;
            $display("FAIL clr_status got locked=%b fault=%b idx=%h want 0/0/ffff", locked, fault, first_idx); end
        tick(4, 4, 4, 0);
        checks++; if (locked !== 1'b1) begin errors++;
            $display("FAIL clr_relock got %b want 1", locked); end
    endtask

    task automatic test_dual_glitch();
        tick(0, 0, 0, 1);
        tick(20, 20, 20, 0);
        tick(22, 25, 21, 0);
        checks++; if (err !== 3'b011 || cnt_b !== 8'd1 || cnt_c !== 8'd1 || cnt_m !== 8'd0) begin errors++;
            $display("FAIL dual_cnt got err=%b b=%0d c=%0d m=%0d want 011/1/1/0", err, cnt_b, cnt_c, cnt_m); end
        tick(0, 23, 22, 0);
        checks++; if (first_exp !== 5'd21 || first_idx !== 16'd0 || cnt_b !== 8'd2) begin errors++;
            $display("FAIL dual_capture got exp=%0d idx=%0d cnt_b=%0d want 21/0/2", first_exp, first_idx, cnt_b); end
    endtask

    task automatic test_majority();
        tick(0, 0, 0, 1);
        tick(5, 5, 9, 0);
`ifdef WPRCNT_CHK_MAJORITY_EN
        checks++; if (locked !== 1'b1) begin errors++;
            $display("FAIL maj_lock got %b want 1", locked); end
`else
        checks++; if (locked !== 1'b0) begin errors++;
            $display("FAIL maj_nolock got %b want 0", locked); end
        tick(5, 5, 5, 0);
`endif
        tick(6, 6, 6, 0);
        checks++; if (locked !== 1'b1 || err !== 3'b000 || samples !== 16'd1) begin errors++;
            $display("FAIL maj_track got locked=%b err=%b samples=%0d want 1/000/1", locked, err, samples); end
    endtask

    task automatic test_random();
        logic [65:0] got, want;
        int v [3];
        int r;
        bit cl;
        tick(0, 0, 0, 1);
        for (int n = 0; n < 600; n++) begin
            r  = int'($urandom_range(0, 99));
            cl = (r < 2);
            if (mode == 1) begin
                for (int i = 0; i < 3; i++)
                    v[i] = ($urandom_range(0, 99) < 5) ? int'($urandom_range(0, 31)) : mexp;
            end else if ($urandom_range(0, 1) == 1) begin
                v[0] = int'($urandom_range(0, 31)); v[1] = v[0]; v[2] = v[0];
                if ($urandom_range(0, 2) == 0) v[$urandom_range(0, 2)] = int'($urandom_range(0, 31));
            end else begin
                for (int i = 0; i < 3; i++) v[i] = int'($urandom_range(0, 31));
            end
            tick(v[0], v[1], v[2], cl);
            got  = {locked, fault, err, cnt_b, cnt_c, cnt_m, first_exp, first_idx, samples};
            want = {mode == 1, mode == 2, merr, 8'(mcnt[0]), 8'(mcnt[1]), 8'(mcnt[2]),
                    5'(mfirst_exp), 16'(mfirst_idx), 16'(msamples)};
            checks++; if (got !== want) begin errors++;
                $display("FAIL random_cycle%0d got %h want %h", n, got, want); end
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_ramp();
        test_wrap();
        test_stuck();
        test_clr_in_fault();
        test_dual_glitch();
        test_majority();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
